pid_sequencer: RTL
==================

// Module: pid_sequencer
// PURPOSE
//  Sample-rate sequencer for the single PID core. Generates the fixed-period sample tick, accepts one feedback sample per tick
//  via valid/ready, and pulses the PID enable for exactly one cycle. It then returns the control word to the actuator side
//  via valid/ready. Gains are double-buffered and committed only on a sample boundary, so a loop never runs with mixed k1/k2/k3.
// PARAMETERS
//  DW        32  data width of reference/feedback/gains/control (two's complement)
//  PERIOD_W  16  width of sample-period register
//  PID_LAT   1   cycles from pid_en-high edge until pid_control holds the new value (>=1)
// PORTS
//  clk           in   1         clock, all logic rising-edge
//  srst          in   1         synchronous reset, active-high
//  start         in   1         1-cycle pulse: IDLE -> running
//  stop          in   1         1-cycle pulse: request return to IDLE
//  period        in   PERIOD_W  sample period in clk cycles; value 0 treated as 1; sampled at each tick reload
//  ref_in        in   DW        setpoint, captured together with the feedback sample
//  cfg_we        in   1         write strobe for gain shadow registers
//  cfg_sel       in   2         0:k1 1:k2 2:k3 3:commit (cfg_data ignored)
//  cfg_data      in   DW        gain write data
//  fb_valid      in   1         feedback sample valid
//  fb_data       in   DW        feedback sample
//  fb_ready      out  1         high only in WAIT_FB
//  pid_en        out  1         PID core enable, 1-cycle pulse per sample
//  pid_reference out  DW        registered setpoint to PID core
//  pid_feedback  out  DW        registered feedback to PID core
//  pid_k1/k2/k3  out  DW        active gains to PID core
//  pid_control   in   DW        PID core output
//  out_valid     out  1         control word valid
//  out_data      out  DW        control word, stable while out_valid && !out_ready
//  out_ready     in   1         actuator accepts
//  busy          out  1         high in any state except IDLE
//  overrun       out  1         sticky: a tick fired outside WAIT_TICK; cleared by srst or start
//  sample_cnt    out  32        completed samples (out handshakes), wraps 2^32-1 -> 0
// BEHAVIOUR
//  srst: state=IDLE; all outputs 0; tick counter 0; shadow gains 0; commit_pend=0; stop_pend=0.
//  Tick counter: active when state!=IDLE; loads max(period,1)-1 on start and at each tick; tick when counter==0.
//  FSM:
//   IDLE      : start -> WAIT_TICK (counter loaded, overrun cleared). stop ignored.
//   WAIT_TICK : tick -> WAIT_FB; if commit_pend, copy shadows to pid_k* this edge and clear commit_pend.
//   WAIT_FB   : fb_valid && fb_ready -> latch fb_data->pid_feedback, ref_in->pid_reference; -> RUN.
//   RUN       : pid_en=1 for this single cycle; -> HOLD with hold counter = PID_LAT.
//   HOLD      : decrement; at 0 latch pid_control->out_data, out_valid=1; -> OUT.
//   OUT       : out_valid && out_ready -> out_valid=0, sample_cnt+1; -> WAIT_TICK (or IDLE if stop_pend).
//  Stop: in WAIT_TICK/WAIT_FB -> IDLE next edge, no pid_en, no output. In RUN/HOLD/OUT -> set stop_pend;
//   the current sample completes its out handshake, then -> IDLE. out_valid never drops without a handshake.
//  Start while busy: ignored. Simultaneous start+stop in IDLE: start wins. stop_pend cleared on IDLE entry.
//  Overrun: tick in any state except WAIT_TICK/IDLE -> overrun=1; that tick is dropped (no extra sample queued);
//   counter still reloads. Minimum overrun-free period = 4+PID_LAT plus fb/out wait cycles.
//  Config: cfg_we with sel 0..2 writes shadow regardless of state; sel 3 sets commit_pend. Commit also takes
//   effect on the start edge from IDLE. Gain write and commit in the same cycle is impossible (single sel).
//  pid_k* never change outside a WAIT_TICK tick edge or start edge. Arithmetic: no math here; pass-through widths DW.
//  srst mid-sample: immediate IDLE; out_valid dropped; pid_k*, shadows cleared.
// TESTING
//  1 period=10, fb_valid held 1, out_ready held 1, start@0 -> pid_en pulses every 10 clk, sample_cnt 1,2,3 each 10 clk.
//  2 write k1=3,k2=-2,k3=1 then commit mid-sample -> pid_k* stay 0 until next tick edge, then 3/-2/1 simultaneously.
//  3 period=3, PID_LAT=1, out_ready low 20 clk -> overrun=1, out_data stable, single sample delivered once ready.
//  4 stop asserted in HOLD -> out_valid rises, after handshake busy=0, no further pid_en.
//  5 fb_valid low for 7 clk after tick, period=20 -> fb_ready high 7 clk, pid_en exactly 1 clk after accept.
//  6 srst asserted in OUT with out_valid=1 -> next edge all outputs 0, state IDLE; start restarts cleanly.

Source files
------------

// File: rtl/pid_sequencer.sv
// Sample-rate sequencer for a single PID core: sample tick, feedback intake,
// one-cycle PID enable, control-word return and sample-aligned gain commit.
module pid_sequencer #(
    parameter int DW       = 32,
    parameter int PERIOD_W = 16,
    parameter int PID_LAT  = 1
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DW-1:0]       ref_in,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [DW-1:0]       cfg_data,
    input  logic                fb_valid,
    input  logic [DW-1:0]       fb_data,
    output logic                fb_ready,
    output logic                pid_en,
    output logic [DW-1:0]       pid_reference,
    output logic [DW-1:0]       pid_feedback,
    output logic [DW-1:0]       pid_k1,
    output logic [DW-1:0]       pid_k2,
    output logic [DW-1:0]       pid_k3,
    input  logic [DW-1:0]       pid_control,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun,
    output logic [31:0]         sample_cnt
);

    localparam int HW = $clog2(PID_LAT + 1);

    localparam logic [HW-1:0] HOLD_INIT = HW'(PID_LAT);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_WAIT_FB   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [DW-1:0]       sh_k1_q, sh_k1_d;
    logic [DW-1:0]       sh_k2_q, sh_k2_d;
    logic [DW-1:0]       sh_k3_q, sh_k3_d;
    logic [DW-1:0]       k1_q, k1_d;
    logic [DW-1:0]       k2_q, k2_d;
    logic [DW-1:0]       k3_q, k3_d;
    logic [DW-1:0]       ref_q, ref_d;
    logic [DW-1:0]       fb_q, fb_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                commit_pend_q, commit_pend_d;
    logic                stop_pend_q, stop_pend_d;
    logic [31:0]         sample_cnt_q, sample_cnt_d;

    logic                tick;
    logic                commit_now;
    logic [PERIOD_W-1:0] reload;

    // A zero period behaves as a tick every cycle.
    assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick   = (state_q != S_IDLE) && (tick_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        hold_d        = hold_q;
        sh_k1_d       = sh_k1_q;
        sh_k2_d       = sh_k2_q;
        sh_k3_d       = sh_k3_q;
        k1_d          = k1_q;
        k2_d          = k2_q;
        k3_d          = k3_q;
        ref_d         = ref_q;
        fb_d          = fb_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        overrun_d     = overrun_q;
        stop_pend_d   = stop_pend_q;
        sample_cnt_d  = sample_cnt_q;
        commit_now    = 1'b0;
        commit_pend_d = commit_pend_q;

        if (state_q != S_IDLE) begin
            tick_cnt_d = tick ? reload : tick_cnt_q - PERIOD_W'(1);
        end

        // A tick that finds the loop still busy is dropped, not queued.
        if (tick && (state_q != S_WAIT_TICK)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WAIT_TICK;
                    tick_cnt_d = reload;
                    overrun_d  = 1'b0;
                    commit_now = commit_pend_q;
                end
            end
            S_WAIT_TICK: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d    = S_WAIT_FB;
                    commit_now = commit_pend_q;
                end
            end
            S_WAIT_FB: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (fb_valid) begin
                    fb_d    = fb_data;
                    ref_d   = ref_in;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_HOLD;
                hold_d  = HOLD_INIT;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            S_HOLD: begin
                hold_d = hold_q - HOLD_ONE;
                if (hold_q == HOLD_ONE) begin
                    out_data_d  = pid_control;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    sample_cnt_d = sample_cnt_q + 32'd1;
                    if (stop_pend_q || stop) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_TICK;
                    end
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_now) begin
            k1_d          = sh_k1_q;
            k2_d          = sh_k2_q;
            k3_d          = sh_k3_q;
            commit_pend_d = 1'b0;
        end

        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    sh_k1_d = cfg_data;
                2'd1:    sh_k2_d = cfg_data;
                2'd2:    sh_k3_d = cfg_data;
                default: commit_pend_d = 1'b1;
            endcase
        end

        if (state_d == S_IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            hold_q        <= '0;
            sh_k1_q       <= '0;
            sh_k2_q       <= '0;
            sh_k3_q       <= '0;
            k1_q          <= '0;
            k2_q          <= '0;
            k3_q          <= '0;
            ref_q         <= '0;
            fb_q          <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            commit_pend_q <= 1'b0;
            stop_pend_q   <= 1'b0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            hold_q        <= hold_d;
            sh_k1_q       <= sh_k1_d;
            sh_k2_q       <= sh_k2_d;
            sh_k3_q       <= sh_k3_d;
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            k3_q          <= k3_d;
            ref_q         <= ref_d;
            fb_q          <= fb_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            commit_pend_q <= commit_pend_d;
            stop_pend_q   <= stop_pend_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

    assign fb_ready      = (state_q == S_WAIT_FB);
    assign pid_en        = (state_q == S_RUN);
    assign busy          = (state_q != S_IDLE);
    assign pid_reference = ref_q;
    assign pid_feedback  = fb_q;
    assign pid_k1        = k1_q;
    assign pid_k2        = k2_q;
    assign pid_k3        = k3_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign overrun       = overrun_q;
    assign sample_cnt    = sample_cnt_q;

endmodule
